// File: rtl/dma_axi_mem_slave.sv
// AXI4 slave with an internal byte-writable RAM: independent read/write bursts (FIXED/INCR), SLVERR on bad beats.
// Define AXI_MEM_STALL_EN to add LFSR-driven backpressure on wready and rvalid.
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

module dma_axi_mem_slave #(
    parameter int          DATA_W    = `AXI_DATA_WIDTH,
    parameter int          MEM_DEPTH = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    localparam int         ID_W      = 4,
    localparam int         MOSI_W    = 2*ID_W + DATA_W + DATA_W/8 + 96,
    localparam int         MISO_W    = 2*ID_W + DATA_W + 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MOSI_W-1:0] axi_mosi_i,
    output logic [MISO_W-1:0] axi_miso_o
);
    localparam int          BYTES     = DATA_W/8;
    localparam int          LSB       = $clog2(BYTES);
    localparam int          AW        = $clog2(MEM_DEPTH);
    localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH*BYTES);
    localparam logic [2:0]  MAX_SIZE  = 3'(LSB);

    typedef struct packed {
        logic [ID_W-1:0]   awid;
        logic [31:0]       awaddr;
        logic [7:0]        awlen;
        logic [2:0]        awsize;
        logic [1:0]        awburst;
        logic              awvalid;
        logic [DATA_W-1:0] wdata;
        logic [BYTES-1:0]  wstrb;
        logic              wlast;
        logic              wvalid;
        logic              bready;
        logic [ID_W-1:0]   arid;
        logic [31:0]       araddr;
        logic [7:0]        arlen;
        logic [2:0]        arsize;
        logic [1:0]        arburst;
        logic              arvalid;
        logic              rready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic              awready;
        logic              wready;
        logic [ID_W-1:0]   bid;
        logic [1:0]        bresp;
        logic              bvalid;
        logic              arready;
        logic [ID_W-1:0]   rid;
        logic [DATA_W-1:0] rdata;
        logic [1:0]        rresp;
        logic              rlast;
        logic              rvalid;
    } s_axi_miso_t;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic       {R_IDLE, R_DATA} rstate_e;

    s_axi_mosi_t mosi;
    s_axi_miso_t miso;
    assign mosi = axi_mosi_i;

    // Unsigned offset compare covers both the lower and upper bound at once.
    function automatic logic beat_ok(input logic [31:0] a, input logic [1:0] burst, input logic [2:0] size);
        return ((a - BASE_ADDR) < MEM_BYTES) && (burst < 2'd2) && (size <= MAX_SIZE);
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        return AW'((a - BASE_ADDR) >> LSB);
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] burst, input logic [2:0] size);
        return (burst == 2'b01) ? a + (32'd1 << size) : a;
    endfunction

    logic stall;
`ifdef AXI_MEM_STALL_EN
    logic [15:0] lfsr_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= 16'hACE1;
        else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // ---------------- write path ----------------
    wstate_e         w_state_q;
    logic [ID_W-1:0] awid_q;
    logic [31:0]     waddr_q;
    logic [7:0]      awlen_q, wcnt_q;
    logic [2:0]      awsize_q;
    logic [1:0]      awburst_q, bresp_q;
    logic            werr_q, awready_q, wready_q, bvalid_q;
    logic            wready, w_hs, w_err;

    assign wready = wready_q & ~stall;
    assign w_hs   = mosi.wvalid & wready;
    assign w_err  = !beat_ok(waddr_q, awburst_q, awsize_q) || (mosi.wlast != (wcnt_q == awlen_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            awid_q    <= '0;
            waddr_q   <= '0;
            awlen_q   <= '0;
            awsize_q  <= '0;
            awburst_q <= '0;
            werr_q    <= 1'b0;
            wcnt_q    <= '0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (mosi.awvalid && awready_q) begin
                        awid_q    <= mosi.awid;
                        waddr_q   <= mosi.awaddr;
                        awlen_q   <= mosi.awlen;
                        awsize_q  <= mosi.awsize;
                        awburst_q <= mosi.awburst;
                        werr_q    <= 1'b0;
                        wcnt_q    <= '0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_state_q <= W_DATA;
                    end
                end
                W_DATA: if (w_hs) begin
                    wcnt_q  <= wcnt_q + 8'd1;
                    waddr_q <= next_addr(waddr_q, awburst_q, awsize_q);
                    werr_q  <= werr_q | w_err;
                    if (wcnt_q == awlen_q) begin
                        wready_q  <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= (werr_q | w_err) ? 2'b10 : 2'b00;
                        w_state_q <= W_RESP;
                    end
                end
                W_RESP: if (mosi.bready) begin
                    bvalid_q  <= 1'b0;
                    bresp_q   <= 2'b00;
                    awready_q <= 1'b1;
                    w_state_q <= W_IDLE;
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (w_hs && !w_err)
            for (int b = 0; b < BYTES; b++)
                if (mosi.wstrb[b]) mem_q[word_idx(waddr_q)][8*b +: 8] <= mosi.wdata[8*b +: 8];
    end

    // ---------------- read path ----------------
    rstate_e           r_state_q;
    logic [ID_W-1:0]   arid_q;
    logic [31:0]       raddr_q, r_addr_nxt;
    logic [7:0]        arlen_q, rcnt_q;
    logic [2:0]        arsize_q;
    logic [1:0]        arburst_q, rresp_q;
    logic              arready_q, rvalid_q, rlast_q;
    logic [DATA_W-1:0] rdata_q;

    assign r_addr_nxt = next_addr(raddr_q, arburst_q, arsize_q);

    // Same-word read/write in one cycle sees the pre-write contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            arid_q    <= '0;
            raddr_q   <= '0;
            arlen_q   <= '0;
            rcnt_q    <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (mosi.arvalid && arready_q) begin
                        arid_q    <= mosi.arid;
                        raddr_q   <= mosi.araddr;
                        arlen_q   <= mosi.arlen;
                        arsize_q  <= mosi.arsize;
                        arburst_q <= mosi.arburst;
                        rcnt_q    <= '0;
                        arready_q <= 1'b0;
                        rvalid_q  <= ~stall;
                        rlast_q   <= (mosi.arlen == 8'd0);
                        if (beat_ok(mosi.araddr, mosi.arburst, mosi.arsize)) begin
                            rdata_q <= mem_q[word_idx(mosi.araddr)];
                            rresp_q <= 2'b00;
                        end else begin
                            rdata_q <= '0;
                            rresp_q <= 2'b10;
                        end
                        r_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (!rvalid_q && !stall) rvalid_q <= 1'b1;
                    if (rvalid_q && mosi.rready) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            rresp_q   <= 2'b00;
                            rdata_q   <= '0;
                            arready_q <= 1'b1;
                            r_state_q <= R_IDLE;
                        end else begin
                            rcnt_q   <= rcnt_q + 8'd1;
                            raddr_q  <= r_addr_nxt;
                            rvalid_q <= ~stall;
                            rlast_q  <= ((rcnt_q + 8'd1) == arlen_q);
                            if (beat_ok(r_addr_nxt, arburst_q, arsize_q)) begin
                                rdata_q <= mem_q[word_idx(r_addr_nxt)];
                                rresp_q <= 2'b00;
                            end else begin
                                rdata_q <= '0;
                                rresp_q <= 2'b10;
                            end
                        end
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    always_comb begin
        miso         = '0;
        miso.awready = awready_q;
        miso.wready  = wready;
        miso.bid     = awid_q;
        miso.bresp   = bresp_q;
        miso.bvalid  = bvalid_q;
        miso.arready = arready_q;
        miso.rid     = arid_q;
        miso.rdata   = rdata_q;
        miso.rresp   = rresp_q;
        miso.rlast   = rlast_q;
        miso.rvalid  = rvalid_q;
    end
    assign axi_miso_o = miso;

endmodule

// File: tb/tb_dma_axi_mem_slave.sv
// Directed self-checking bench for dma_axi_mem_slave (32-bit data, 1024 words, base 0).
module tb_dma_axi_mem_slave;
    localparam int DW     = 32;
    localparam int IDW    = 4;
    localparam int MOSI_W = 2*IDW + DW + DW/8 + 96;
    localparam int MISO_W = 2*IDW + DW + 10;

    typedef struct packed {
        logic [IDW-1:0] awid;   logic [31:0] awaddr; logic [7:0] awlen; logic [2:0] awsize;
        logic [1:0] awburst;    logic awvalid;
        logic [DW-1:0] wdata;   logic [DW/8-1:0] wstrb; logic wlast; logic wvalid;
        logic bready;
        logic [IDW-1:0] arid;   logic [31:0] araddr; logic [7:0] arlen; logic [2:0] arsize;
        logic [1:0] arburst;    logic arvalid;
        logic rready;
    } mosi_t;

    typedef struct packed {
        logic awready; logic wready; logic [IDW-1:0] bid; logic [1:0] bresp; logic bvalid;
        logic arready; logic [IDW-1:0] rid; logic [DW-1:0] rdata; logic [1:0] rresp;
        logic rlast; logic rvalid;
    } miso_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    mosi_t mo;
    miso_t mi;
    logic [MOSI_W-1:0] mosi_v;
    logic [MISO_W-1:0] miso_v;
    assign mosi_v = mo;
    assign mi = miso_v;

    always #5 clk = ~clk;

    dma_axi_mem_slave u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .axi_mosi_i (mosi_v),
        .axi_miso_o (miso_v)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] wbuf [16];
    logic [3:0]  sbuf [16];
    logic [31:0] rbuf [16];
    logic [1:0]  rrbuf [16];
    logic        rlbuf [16];
    int          rgap [16];
    logic [1:0]  bresp_r;
    logic [3:0]  bid_r, rid_r;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input bit bad_last);
        int t;
        mo.awid = id; mo.awaddr = addr; mo.awlen = len; mo.awsize = size; mo.awburst = burst;
        mo.awvalid = 1'b1;
        t = 0;
        while (!mi.awready && t < 50) begin step(); t++; end
        chk("aw_rdy", mi.awready, 1);
        step();
        mo.awvalid = 1'b0;
        chk("wready_lat", mi.wready, 1);
        for (int i = 0; i <= int'(len); i++) begin
            mo.wdata = wbuf[i]; mo.wstrb = sbuf[i];
            mo.wlast = (i == int'(len)) ^ bad_last;
            mo.wvalid = 1'b1;
            t = 0;
            while (!mi.wready && t < 50) begin step(); t++; end
            step();
        end
        mo.wvalid = 1'b0; mo.wlast = 1'b0;
        chk("b_lat", mi.bvalid, 1);
        t = 0;
        while (!mi.bvalid && t < 50) begin step(); t++; end
        bresp_r = mi.bresp; bid_r = mi.bid;
        mo.bready = 1'b1;
        step();
        mo.bready = 1'b0;
        chk("b_drop", mi.bvalid, 0);
        chk("aw_back", mi.awready, 1);
    endtask

    task automatic rd_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        int t;
        mo.arid = id; mo.araddr = addr; mo.arlen = len; mo.arsize = size; mo.arburst = burst;
        mo.arvalid = 1'b1; mo.rready = 1'b1;
        t = 0;
        while (!mi.arready && t < 50) begin step(); t++; end
        chk("ar_rdy", mi.arready, 1);
        step();
        mo.arvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            t = 0;
            while (!mi.rvalid && t < 50) begin step(); t++; end
            rgap[i] = t; rbuf[i] = mi.rdata; rrbuf[i] = mi.rresp; rlbuf[i] = mi.rlast; rid_r = mi.rid;
            step();
        end
        mo.rready = 1'b0;
        chk("r_done", mi.rvalid, 0);
    endtask

    task automatic wr1(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        wbuf[0] = data; sbuf[0] = strb;
        wr_burst(4'd0, addr, 8'd0, 3'd2, 2'b01, 1'b0);
    endtask

    task automatic rd1(input logic [31:0] addr);
        rd_burst(4'd0, addr, 8'd0, 3'd2, 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic seen_b;
        mo = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", {mi.awready, mi.wready, mi.bvalid, mi.arready, mi.rvalid, mi.rlast}, 6'b0);
        chk("rst_rdata", mi.rdata, 0);
        chk("rst_resp", {mi.bresp, mi.rresp}, 4'b0);
        rst_n = 1'b1;
        #1;
        chk("rdy_pre_edge", {mi.awready, mi.arready}, 2'b00);
        step();
        chk("rdy_post_edge", {mi.awready, mi.arready}, 2'b11);

        // single write / read
        wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
        wr_burst(4'd3, 32'h10, 8'd0, 3'd2, 2'b01, 1'b0);
        chk("single_bresp", bresp_r, 2'b00);
        chk("single_bid", bid_r, 4'd3);
        rd_burst(4'd5, 32'h10, 8'd0, 3'd2, 2'b01);
        chk("single_rdata", rbuf[0], 32'hDEADBEEF);
        chk("single_rlast", rlbuf[0], 1);
        chk("single_rresp", rrbuf[0], 2'b00);
        chk("single_rid", rid_r, 4'd5);
        chk("single_rlat", rgap[0], 0);

        // INCR 8-beat burst
        for (int i = 0; i < 8; i++) begin wbuf[i] = 32'(i); sbuf[i] = 4'hF; end
        wr_burst(4'd1, 32'h100, 8'd7, 3'd2, 2'b01, 1'b0);
        chk("incr_bresp", bresp_r, 2'b00);
        rd_burst(4'd2, 32'h100, 8'd7, 3'd2, 2'b01);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("incr_d%0d", i), rbuf[i], 32'(i));
            chk($sformatf("incr_last%0d", i), rlbuf[i], (i == 7) ? 1 : 0);
            chk($sformatf("incr_gap%0d", i), rgap[i], 0);
        end

        // byte strobes
        wr1(32'h200, 32'hFFFFFFFF, 4'hF);
        wr1(32'h200, 32'h11223344, 4'b0101);
        rd1(32'h200);
        chk("strb_rdata", rbuf[0], 32'hFF22FF44);

        // FIXED burst: all beats land on one word
        wr1(32'h44, 32'h5555AAAA, 4'hF);
        wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC; wbuf[3] = 32'hD;
        for (int i = 0; i < 4; i++) sbuf[i] = 4'hF;
        wr_burst(4'd0, 32'h40, 8'd3, 3'd2, 2'b00, 1'b0);
        chk("fixed_bresp", bresp_r, 2'b00);
        rd1(32'h40);
        chk("fixed_rdata", rbuf[0], 32'hD);
        rd1(32'h44);
        chk("fixed_neighbour", rbuf[0], 32'h5555AAAA);

        // out-of-range write must not alias onto word 0
        wr1(32'h0, 32'h0BADF00D, 4'hF);
        chk("w0_bresp", bresp_r, 2'b00);
        wr1(32'h1000, 32'hFFFFFFFF, 4'hF);
        chk("oor_bresp", bresp_r, 2'b10);
        rd1(32'h0);
        chk("oor_no_change", rbuf[0], 32'h0BADF00D);

        rd_burst(4'd7, 32'h1000, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("oor_rd_d%0d", i), rbuf[i], 0);
            chk($sformatf("oor_rd_resp%0d", i), rrbuf[i], 2'b10);
            chk($sformatf("oor_rd_last%0d", i), rlbuf[i], (i == 3) ? 1 : 0);
        end

        // last in-range word
        wr1(32'hFFC, 32'hCAFEF00D, 4'hF);
        chk("top_bresp", bresp_r, 2'b00);
        rd1(32'hFFC);
        chk("top_rdata", rbuf[0], 32'hCAFEF00D);
        chk("top_rresp", rrbuf[0], 2'b00);

        // WRAP, oversize and bad wlast
        wr1(32'h300, 32'h12345678, 4'hF);
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hEEEE0000 + 32'(i); sbuf[i] = 4'hF; end
        wr_burst(4'd2, 32'h300, 8'd3, 3'd2, 2'b10, 1'b0);
        chk("wrap_bresp", bresp_r, 2'b10);
        rd1(32'h300);
        chk("wrap_no_change", rbuf[0], 32'h12345678);
        rd_burst(4'd1, 32'h300, 8'd1, 3'd2, 2'b10);
        chk("wrap_rresp0", rrbuf[0], 2'b10);
        chk("wrap_rresp1", rrbuf[1], 2'b10);
        wbuf[0] = 32'h1; sbuf[0] = 4'hF;
        wr_burst(4'd0, 32'h304, 8'd0, 3'd3, 2'b01, 1'b0);
        chk("size_bresp", bresp_r, 2'b10);
        wr_burst(4'd0, 32'h308, 8'd0, 3'd2, 2'b01, 1'b1);
        chk("wlast_bresp", bresp_r, 2'b10);

        // asynchronous reset during beat 2 of an 8-beat write
        mo.awid = 4'd9; mo.awaddr = 32'h500; mo.awlen = 8'd7; mo.awsize = 3'd2; mo.awburst = 2'b01;
        mo.awvalid = 1'b1;
        step();
        mo.awvalid = 1'b0;
        mo.wstrb = 4'hF; mo.wvalid = 1'b1; mo.wdata = 32'h0; mo.wlast = 1'b0;
        step();
        mo.wdata = 32'h1;
        step();
        mo.wdata = 32'h2;
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_wready", mi.wready, 0);
        chk("abort_bvalid", mi.bvalid, 0);
        chk("abort_awready", mi.awready, 0);
        mo.wvalid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        seen_b = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            seen_b |= mi.bvalid;
        end
        chk("abort_no_b", seen_b, 0);
        wr1(32'h504, 32'h600DD00D, 4'hF);
        chk("post_rst_bresp", bresp_r, 2'b00);
        rd1(32'h504);
        chk("post_rst_rdata", rbuf[0], 32'h600DD00D);
        chk("post_rst_rresp", rrbuf[0], 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dma_axi_mem_slave.md
# dma_axi_mem_slave

AXI4 slave responder with an internal synthesizable byte-writable RAM. It terminates the DMA master interface (`s_axi_mosi_t` / `s_axi_miso_t`) and serves as the source and destination memory in DMA block and system benches. It accepts independent read and write bursts (FIXED/INCR), returns SLVERR for unsupported or out-of-range accesses, and can optionally inject pseudo-random backpressure.

## Interface
- `DATA_W`, default `` `AXI_DATA_WIDTH ``: data bus width (32 or 64).
- `MEM_DEPTH`, default 1024: number of `DATA_W`-bit words; power of two.
- `BASE_ADDR`, default 0: byte address of word 0; aligned to `MEM_DEPTH*DATA_W/8`.
- `clk`, input, 1: the single clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `axi_mosi_i`, input, `$bits(s_axi_mosi_t)`: AW/W/AR channels plus bready/rready from the DMA master.
- `axi_miso_o`, output, `$bits(s_axi_miso_t)`: awready/wready/B/arready/R channels.

## Operation
- Derived constants:
  - BYTES = DATA_W/8.
  - LSB = log2(BYTES).
  - word index = (addr − BASE_ADDR) >> LSB.
- In-range condition: BASE_ADDR ≤ addr < BASE_ADDR + MEM_DEPTH*BYTES.
- Write FSM states:
  - **W_IDLE**: awready=1. An AW handshake latches awid, awaddr, awlen, awsize and awburst, clears the error flag and beat counter, then moves to W_DATA.
  - **W_DATA**: wready=1. Each W handshake writes the byte lanes selected by wstrb to the current word, unless the beat is errored. For INCR, addr += 2^awsize after each beat; for FIXED, addr is held. Leave to W_RESP when the beat counter equals awlen.
  - **W_RESP**: bvalid=1, bid=latched awid, bresp=2'b10 if the error flag is set, else 2'b00. A bready handshake returns to W_IDLE.
- A write beat is errored if any of these hold:
  - the address is out of range;
  - awburst is WRAP or reserved;
  - awsize > LSB;
  - wlast ≠ (beat counter == awlen).

  An errored beat sets the sticky error flag, and its data is dropped.
- The burst always terminates by beat count (awlen+1 beats); wlast is checked, not trusted.
- Read FSM states:
  - **R_IDLE**: arready=1. An AR handshake latches arid, araddr, arlen, arsize and arburst, then moves to R_DATA.
  - **R_DATA**: rdata comes from a registered RAM read. rid=latched arid, rlast=1 on beat arlen. rresp=2'b10 per beat if that beat is out of range, has a bad burst, or has a bad size; such beats return rdata=0. After the handshake of the last beat, return to R_IDLE.
- Read and write paths are fully independent. When a read and a write hit the same word in the same cycle, the read returns the old data.
- Address increments wrap modulo 2^32; 4 KB boundary crossings are not checked.

## Timing
- Reset values (while rst_n=0):
  - all valid/ready outputs = 0;
  - bresp = rresp = 0, rdata = 0, rlast = 0;
  - both FSMs in IDLE.
- awready and arready go to 1 on the first clk edge after rst_n rises. The RAM contents are not reset.
- AW handshake at cycle N: wready=1 at N+1, so one W beat per cycle is possible.
- Last W handshake at cycle M: bvalid=1 at M+1 and is held until bready.
- AR handshake at cycle N: first rvalid at N+1. Each subsequent beat follows one cycle after the previous beat's handshake, giving full throughput with rready held high.
- rvalid, rdata, rresp and rlast are stable while rvalid=1 and rready=0.
- awready is 0 from the AW handshake until the B handshake, so only one outstanding write is allowed. arready is likewise 0 until the last R handshake.
- An asynchronous reset in any state aborts the burst. Outputs return to reset values immediately, and no B or R response is generated for the aborted burst.

## Configuration
- Macro `` `AXI_MEM_STALL_EN ``.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16, 14, 13, 11; reset value 16'hACE1) advances every cycle.
  - When lfsr[1:0]==2'b00, wready is forced to 0 in W_DATA that cycle.
  - When lfsr[1:0]==2'b00, the assertion of rvalid for the next beat is delayed by one cycle.
  - Once rvalid is high it is never withdrawn.
  - bvalid and the AW/AR ready signals are unaffected.
- Undefined: no LFSR is instantiated, there are zero stall cycles, and the timing is exactly as above.

## Test plan
- Single write: 0xDEADBEEF to 0x10 with wstrb 0xF, awid 3. Required: bresp 0, bid 3, bvalid one cycle after the W beat. A read of 0x10 returns 0xDEADBEEF, rlast=1, rresp 0.
- INCR burst: awlen 7, awsize=LSB, data 0..7 written at 0x100. Read back with arlen 7 and rready held high. Required: 8 consecutive rvalid cycles carrying 0..7, with rlast only on beat 7.
- Byte strobes: write 0xFFFFFFFF, then write 0x11223344 with wstrb 4'b0101. Required: read returns 0xFF22FF44.
- FIXED burst: awlen 3 to 0x40 with data A, B, C, D. Required: read of 0x40 returns D, and 0x44 is unchanged.
- Errors:
  - write to BASE_ADDR + MEM_DEPTH*BYTES → bresp 2'b10 and no RAM change;
  - a 4-beat read there → rdata 0, rresp 2'b10 on every beat, rlast on beat 3;
  - WRAP burst → SLVERR.
- Reset mid-burst: drop rst_n during beat 2 of an 8-beat write. Required: wready and bvalid are 0 immediately, no B response is produced, and a following single write/read completes with OKAY.
